// File: rtl/dist_pkg.sv
// Shared types and helpers for the path segment emitter and its accumulator.
package dist_pkg;

  localparam int COORD_W     = 4;
  localparam int ACC_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    HOLD
  } seg_state_t;

  // |x - y| for unsigned coordinates, via a one-bit-wider signed difference.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic signed [COORD_W:0] d;
    logic signed [COORD_W:0] m;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    m = d[COORD_W] ? -d : d;
    return m[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/wp_fifo.sv
// Waypoint FIFO: registered occupancy, head visible combinationally, no bypass.
module wp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/path_segment_emitter.sv
// Buffers waypoints and emits per-segment |dx|,|dy| as one unbroken valid burst,
// followed by zero-delta hold beats covering the accumulator latency.
module path_segment_emitter
  import dist_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = ACC_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] wp_x,
  input  logic [COORD_W-1:0] wp_y,
  input  logic               wp_valid,
  output logic               wp_ready,
  input  logic               path_start,
  input  logic [CNT_W-1:0]   path_len,
  output logic [COORD_W-1:0] a,
  output logic [COORD_W-1:0] b,
  output logic               valid,
  output logic               busy,
  output logic               path_done,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int                 DW        = 2 * COORD_W;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC);

  seg_state_t           r_state;
  logic [CNT_W-1:0]     r_remaining;
  logic [CNT_W-1:0]     r_hold;
  logic [COORD_W-1:0]   r_prev_x;
  logic [COORD_W-1:0]   r_prev_y;
  logic [COORD_W-1:0]   r_a;
  logic [COORD_W-1:0]   r_b;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     r_stall;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [DW-1:0]        w_head;
  logic [COORD_W-1:0]   w_head_x;
  logic [COORD_W-1:0]   w_head_y;
  // Occupancy is not needed here: full/empty cover every decision.
  logic [$clog2(DEPTH):0] w_count_unused;

  assign wp_ready  = !w_full;
  assign w_pop     = ((r_state == PRIME) || (r_state == RUN)) && !w_empty;
  assign w_head_x  = w_head[DW-1:COORD_W];
  assign w_head_y  = w_head[COORD_W-1:0];

  assign a         = r_a;
  assign b         = r_b;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign path_done = r_done;
  assign stall_cnt = r_stall;

  wp_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wp_valid),
    .din   ({wp_x, wp_y}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count_unused)
  );

  // Path sequencer with registered outputs. RUN always has remaining >= 1,
  // so the pop that brings it to zero is the last segment. HOLD spends
  // HOLD_CYC valid beats plus one extra cycle that drops valid and pulses done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_hold      <= '0;
      r_prev_x    <= '0;
      r_prev_y    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stall     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
          r_done  <= 1'b0;
          if (path_start && (path_len != '0)) begin
            r_remaining <= path_len;
            r_stall     <= '0;
            r_busy      <= 1'b1;
            r_state     <= PRIME;
          end
        end
        PRIME: begin
          if (!w_empty) begin
            r_prev_x <= w_head_x;
            r_prev_y <= w_head_y;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_valid <= 1'b1;
          if (!w_empty) begin
            r_a         <= abs_diff(w_head_x, r_prev_x);
            r_b         <= abs_diff(w_head_y, r_prev_y);
            r_prev_x    <= w_head_x;
            r_prev_y    <= w_head_y;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_hold  <= '0;
              r_state <= HOLD;
            end
          end else begin
            r_a <= '0;
            r_b <= '0;
            if (r_stall != '1) r_stall <= r_stall + 1'b1;
          end
        end
        HOLD: begin
          r_a <= '0;
          r_b <= '0;
          if (r_hold == HOLD_LAST) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_valid <= 1'b1;
            r_hold  <= r_hold + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/path_segment_emitter.md
# path_segment_emitter

Producer for the distance accumulator's `a`/`b`/`valid` input stream. It buffers incoming (x, y) waypoints and emits per-segment absolute deltas |dx|, |dy| as one unbroken `valid` burst per path. It then holds `valid` high with zero deltas long enough for the accumulator pipeline to settle before signalling completion. The accumulator clears whenever `valid` is low, so the emitter never lets `valid` drop inside a path.

## Interface
- `DEPTH`, 4 — waypoint FIFO entries (power of two, ≥2)
- `CNT_W`, 8 — width of the path length and stall counters
- `HOLD_CYC`, 4 — zero-delta beats after the last segment; equals the accumulator latency

- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `wp_x`  in  4  — waypoint x coordinate, unsigned
- `wp_y`  in  4  — waypoint y coordinate, unsigned
- `wp_valid`  in  1  — waypoint offered
- `wp_ready`  out  1  — FIFO not full; a push occurs when `wp_valid && wp_ready`
- `path_start`  in  1  — one-cycle command to begin a path
- `path_len`  in  CNT_W  — segment count, sampled with `path_start`
- `a`  out  4  — segment |dx|
- `b`  out  4  — segment |dy|
- `valid`  out  1  — drives the accumulator's `valid`
- `busy`  out  1  — high in every state except IDLE
- `path_done`  out  1  — one-cycle pulse after the hold completes
- `stall_cnt`  out  CNT_W  — zero-delta filler beats inserted in the current or last path; saturates

## Operation
- **FSM states:** IDLE, PRIME, RUN, HOLD.
- **IDLE**
  - `valid`=0, `a`=`b`=0.
  - `path_start` with `path_len`≠0 latches `remaining`=`path_len`, clears `stall_cnt`, and moves to PRIME.
  - `path_start` with `path_len`=0 is ignored.
- **PRIME**
  - `valid` stays 0.
  - When the FIFO is non-empty, pop one waypoint into `prev` and move to RUN.
- **RUN**
  - Every cycle `valid`=1.
  - FIFO non-empty: pop, set `a`=|x−prev_x|, `b`=|y−prev_y|, `prev`←popped, `remaining`−1.
  - FIFO empty: `a`=`b`=0 and `stall_cnt`+1.
  - Leave for HOLD on the cycle `remaining` reaches 0.
- **HOLD**
  - `HOLD_CYC` beats of `valid`=1, `a`=`b`=0, counted by an internal counter.
  - After the last beat, pulse `path_done` and return to IDLE.
  - The accumulator total is final during the `path_done` cycle.
- **Deltas:** computed in 5-bit signed, then magnitude; always 0..15.
- **FIFO pushes** are accepted in every state, including IDLE, so waypoints may be preloaded.
- **Commands while busy:** `path_start` is ignored while `busy`=1.
- **Waypoint count:** a path of N segments consumes N+1 waypoints. Leftover FIFO entries remain for the next path.
- **`stall_cnt` saturation:** at 2^CNT_W−1.

## Timing
- **Registering:** all outputs are registered. `wp_ready` comes combinationally from the FIFO count registers.
- **Reset values:** `a`=0, `b`=0, `valid`=0, `busy`=0, `path_done`=0, `stall_cnt`=0, `wp_ready`=1. FIFO empty, state IDLE.
- **Reset mid-operation:** everything is discarded immediately, including FIFO contents. `valid` falls asynchronously.
- **PRIME timing**
  - With the FIFO already non-empty, PRIME lasts 1 cycle.
  - The first `valid`=1 beat appears 2 cycles after the `path_start` edge.
- **FIFO has no bypass**
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A push into an empty FIFO is visible to pop on the next cycle; that cycle still counts as a stall.
- **Full FIFO:** `wp_ready`=0, and `wp_valid` is ignored.
- **Burst length:** `valid` is high for exactly `path_len` + `stall_cnt` + `HOLD_CYC` consecutive cycles.
- **Back-to-back paths:** `valid` is low for at least 2 cycles between paths (IDLE, PRIME), which clears the accumulator.

## Structure
- **Package `dist_pkg`:**
  - `COORD_W`=4
  - `ACC_LATENCY`=4, the default for `HOLD_CYC`
  - state enum `seg_state_t` {IDLE, PRIME, RUN, HOLD}
  - a function for the absolute difference of two unsigned values
- **Sub-module `wp_fifo`:**
  - parameterised by `DEPTH` and data width 8
  - ports: push, pop, full, empty, count
  - the emitter instantiates it once

## Test plan
- **Basic path:** preload (0,0), (3,4), (6,8); `path_start`, `path_len`=2.
  - `a`/`b` = 3/4, 3/4, then 4 beats of 0/0, all with `valid`=1; then `path_done`.
  - The accumulator reads total 10.
- **Negative delta:** waypoints (5,5)→(2,9), `path_len`=1 → `a`=3, `b`=4. (15,0)→(0,15) → `a`=15, `b`=15.
- **Stall:** feed (0,0), (3,4), withhold the third waypoint 3 cycles, then send (6,8).
  - Three 0/0 beats with `valid` held high; `stall_cnt`=3.
  - The accumulator total is still 10.
- **FIFO full:** with `DEPTH`=4 in IDLE, offer 5 waypoints.
  - `wp_ready` drops after the 4th; the 5th is held until a pop.
- **Ignored commands:**
  - `path_start` during RUN leaves the path unchanged.
  - `path_len`=0 in IDLE leaves `busy`=0.
- **Reset mid-RUN:** assert `rst` low.
  - `valid`=0, `busy`=0, `stall_cnt`=0, `wp_ready`=1 at once.
  - The next path starts with an empty FIFO.
